// File: rtl/step_ramp_ctrl.sv
// Stepper move sequencer: accepts move commands and emits a linearly ramped step pulse train.
// Optional STEP_RAMP_CTRL_POS_EN adds a signed 32-bit step position counter output.
module step_ramp_ctrl #(
  parameter int unsigned SIZE         = 16,
  parameter int unsigned START_PERIOD = 2000,
  parameter int unsigned ACCEL_STEP   = 50,
  parameter int unsigned MIN_PERIOD   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            drv_en_SM,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SIZE-1:0] cmd_steps,
  input  logic [SIZE-1:0] cmd_period,
  input  logic            cmd_dir,
  input  logic            stop,
  output logic            step,
  output logic            dir,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] steps_left
`ifdef STEP_RAMP_CTRL_POS_EN
  ,
  output logic signed [31:0] position
`endif
);

  localparam int unsigned PW = SIZE + 1;
  localparam logic [PW-1:0] START_W = PW'(START_PERIOD);
  localparam logic [PW-1:0] ACCEL_W = PW'(ACCEL_STEP);
  localparam logic [PW-1:0] MIN_W   = PW'(MIN_PERIOD);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEL  = 2'd1;
  localparam logic [1:0] CRUISE = 2'd2;
  localparam logic [1:0] DECEL  = 2'd3;

  logic [1:0]      state, state_n;
  logic [SIZE-1:0] period, period_n;
  logic [SIZE-1:0] tgt, tgt_n;
  logic [SIZE-1:0] acc_cnt, acc_n;
  logic [SIZE-1:0] steps_n;
  logic [SIZE-1:0] cnt, cnt_n;
  logic            stop_req, stop_req_n;
  logic            zero_pend, zero_pend_n;
  logic            dir_n, done_n, step_n;
  logic [SIZE-1:0] sl, sl_dec, thr;
  logic [PW-1:0]   cp, p_ext;

  assign cmd_ready = (state == IDLE) && drv_en_SM && !stop;
  assign busy      = (state != IDLE);

  // Next-state and datapath update; a boundary is any busy cycle with cnt == period.
  always_comb begin
    state_n     = state;
    period_n    = period;
    tgt_n       = tgt;
    acc_n       = acc_cnt;
    steps_n     = steps_left;
    cnt_n       = cnt;
    stop_req_n  = stop_req;
    zero_pend_n = 1'b0;
    dir_n       = dir;
    done_n      = 1'b0;
    sl          = steps_left;
    sl_dec      = steps_left;
    cp          = {1'b0, cmd_period};
    p_ext       = '0;
    thr         = '0;
    step_n      = 1'b0;
    case (state)
      IDLE: begin
        stop_req_n = 1'b0;
        done_n     = zero_pend;
        if (cmd_valid && cmd_ready) begin
          dir_n = cmd_dir;
          if (cp < MIN_W)        tgt_n = SIZE'(MIN_W);
          else if (cp > START_W) tgt_n = SIZE'(START_W);
          else                   tgt_n = cmd_period;
          // Preload cnt == period so the first cycle after acceptance is a boundary.
          period_n = SIZE'(START_W);
          cnt_n    = SIZE'(START_W);
          acc_n    = '0;
          steps_n  = cmd_steps;
          if (cmd_steps == '0) zero_pend_n = 1'b1;
          else                 state_n     = ACCEL;
        end
      end
      default: begin
        if (!drv_en_SM) begin
          state_n    = IDLE;
          done_n     = 1'b1;
          stop_req_n = 1'b0;
        end else if (cnt != period) begin
          cnt_n      = cnt + SIZE'(1);
          stop_req_n = stop_req | stop;
        end else begin
          sl         = (stop_req && (acc_cnt < steps_left)) ? acc_cnt : steps_left;
          stop_req_n = stop;
          if (sl == '0) begin
            state_n    = IDLE;
            done_n     = 1'b1;
            steps_n    = '0;
            stop_req_n = 1'b0;
          end else begin
            sl_dec  = sl - SIZE'(1);
            steps_n = sl_dec;
            cnt_n   = SIZE'(1);
            if (sl_dec <= acc_cnt) begin
              state_n  = DECEL;
              p_ext    = {1'b0, period} + ACCEL_W;
              period_n = (p_ext > START_W) ? SIZE'(START_W) : SIZE'(p_ext);
              acc_n    = (acc_cnt == '0) ? '0 : acc_cnt - SIZE'(1);
            end else if (period > tgt) begin
              state_n  = ACCEL;
              p_ext    = {1'b0, tgt} + ACCEL_W;
              period_n = ({1'b0, period} > p_ext) ? SIZE'({1'b0, period} - ACCEL_W) : tgt;
              acc_n    = acc_cnt + SIZE'(1);
            end else begin
              state_n = CRUISE;
            end
          end
        end
      end
    endcase
    thr = period_n >> 2;
    if (thr == '0) thr = SIZE'(1);
    step_n = (state_n != IDLE) && (cnt_n <= thr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      period     <= '0;
      tgt        <= '0;
      acc_cnt    <= '0;
      steps_left <= '0;
      cnt        <= '0;
      stop_req   <= 1'b0;
      zero_pend  <= 1'b0;
      dir        <= 1'b0;
      done       <= 1'b0;
      step       <= 1'b0;
    end else begin
      state      <= state_n;
      period     <= period_n;
      tgt        <= tgt_n;
      acc_cnt    <= acc_n;
      steps_left <= steps_n;
      cnt        <= cnt_n;
      stop_req   <= stop_req_n;
      zero_pend  <= zero_pend_n;
      dir        <= dir_n;
      done       <= done_n;
      step       <= step_n;
    end
  end

`ifdef STEP_RAMP_CTRL_POS_EN
  logic issue;
  assign issue = (state != IDLE) && drv_en_SM && (cnt == period) && (sl != '0);

  // Position follows each issued step in the latched direction.
  always_ff @(posedge clk) begin
    if (rst)        position <= 32'sd0;
    else if (issue) position <= dir ? position + 32'sd1 : position - 32'sd1;
  end
`endif

endmodule

// File: tb/tb_step_ramp_ctrl.sv
// Bench for step_ramp_ctrl: directed vector table, corner sequences, and random moves vs a step-level model.
module tb_step_ramp_ctrl;

  localparam int unsigned SIZE = 16;
  localparam int SP = 100;
  localparam int AS = 20;
  localparam int MP = 4;

  logic            clk;
  logic            rst;
  logic            drv_en_SM;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_steps;
  logic [SIZE-1:0] cmd_period;
  logic            cmd_dir;
  logic            stop;
  logic            step;
  logic            dir;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] steps_left;
`ifdef STEP_RAMP_CTRL_POS_EN
  logic signed [31:0] position;
`endif

  step_ramp_ctrl #(
    .SIZE(SIZE), .START_PERIOD(SP), .ACCEL_STEP(AS), .MIN_PERIOD(MP)
  ) dut (
    .clk(clk), .rst(rst), .drv_en_SM(drv_en_SM), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .cmd_dir(cmd_dir), .stop(stop), .step(step), .dir(dir), .busy(busy),
    .done(done), .steps_left(steps_left)
`ifdef STEP_RAMP_CTRL_POS_EN
    , .position(position)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int rise_q[$];
  int hi_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected step count and acceptance-to-done latency, computed one step at a time.
  function automatic void model(input int steps, input int per, output int n, output int lat);
    int tgt, p, acc, sl;
    tgt = (per < MP) ? MP : ((per > SP) ? SP : per);
    p = SP; acc = 0; sl = steps; n = 0; lat = 1;
    while (sl > 0) begin
      sl--;
      if (sl <= acc) begin
        p = (p + AS > SP) ? SP : p + AS;
        acc = (acc > 0) ? acc - 1 : 0;
      end else if (p > tgt) begin
        p = (p - AS < tgt) ? tgt : p - AS;
        acc++;
      end
      n++;
      lat += p;
    end
  endfunction

  // Issue one command and follow it to done, recording rising-edge times and pulse widths.
  task automatic run_move(input int steps, input int per, input bit d,
                          input int stop_rise, input int stop_dly,
                          input int drop_rise, input int drop_dly,
                          output int n, output int lat, output int sl_done, output bit to);
    int c, since;
    bit prev;
    rise_q.delete();
    hi_q.delete();
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(per);
    cmd_dir    = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0; lat = 0; sl_done = -1; to = 1'b0; c = 0; since = 0; prev = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      c++;
      stop = 1'b0;
      if (step && !prev) begin
        n++;
        rise_q.push_back(c);
        hi_q.push_back(1);
        since = 0;
      end else begin
        since++;
        if (step && hi_q.size() > 0) hi_q[hi_q.size()-1]++;
      end
      prev = step;
      if (done) begin
        lat = c;
        sl_done = int'(steps_left);
        break;
      end
      if (n == stop_rise && since == stop_dly) stop = 1'b1;
      if (n == drop_rise && since == drop_dly) drv_en_SM = 1'b0;
      if (c > 20000) begin
        to = 1'b1;
        break;
      end
    end
    stop = 1'b0;
  endtask

  typedef struct {
    int steps;
    int per;
    bit d;
    int exp_n;
    int exp_lat;
    int exp_hi;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, lat, sl, en, elat, steps, per;
    bit to, d;
    int exp_pos;

    tbl[0] = '{5,   100, 1'b1, 5,  501, 25};
    tbl[1] = '{10,  40,  1'b0, 10, 641, 20};
    tbl[2] = '{0,   50,  1'b1, 0,  1,   0};
    tbl[3] = '{3,   2,   1'b1, 3,  281, 20};
    tbl[4] = '{1,   500, 1'b0, 1,  101, 25};
    tbl[5] = '{2,   60,  1'b1, 2,  181, 20};

    rst = 1'b1; drv_en_SM = 1'b1; stop = 1'b0; cmd_valid = 1'b0;
    cmd_steps = '0; cmd_period = '0; cmd_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_steps_left", int'(steps_left), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      run_move(tbl[i].steps, tbl[i].per, tbl[i].d, -1, 0, -1, 0, n, lat, sl, to);
      chk($sformatf("tbl%0d_timeout", i), int'(to), 0);
      chk($sformatf("tbl%0d_nsteps", i), n, tbl[i].exp_n);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_dir", i), int'(dir), int'(tbl[i].d));
      chk($sformatf("tbl%0d_steps_left", i), sl, 0);
      if (tbl[i].exp_n > 0) chk($sformatf("tbl%0d_high", i), hi_q[0], tbl[i].exp_hi);
    end

    // Controlled stop during the fifth interval of a ramped move.
    run_move(10, 40, 1'b1, 5, 3, -1, 0, n, lat, sl, to);
    chk("stop_timeout", int'(to), 0);
    chk("stop_nsteps", n, 8);
    chk("stop_steps_left", sl, 0);
    if (rise_q.size() == 8) begin
      chk("stop_int5", rise_q[5] - rise_q[4], 40);
      chk("stop_int6", rise_q[6] - rise_q[5], 60);
      chk("stop_int7", rise_q[7] - rise_q[6], 80);
      chk("stop_tail", lat - rise_q[7], 100);
    end

    // Driver enable drop with six steps unissued.
    run_move(10, 40, 1'b0, -1, 0, 4, 2, n, lat, sl, to);
    chk("drop_timeout", int'(to), 0);
    chk("drop_nsteps", n, 4);
    chk("drop_step", int'(step), 0);
    chk("drop_busy", int'(busy), 0);
    chk("drop_steps_left", sl, 6);
    chk("drop_ready", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    chk("drop_done_once", int'(done), 0);
    chk("drop_ready_hold", int'(cmd_ready), 0);
    drv_en_SM = 1'b1;
    #1;
    chk("drop_ready_back", int'(cmd_ready), 1);

    // Minimum period clamp: cruise at four clocks with one-clock pulses.
    run_move(20, 2, 1'b1, -1, 0, -1, 0, n, lat, sl, to);
    chk("min_nsteps", n, 20);
    if (rise_q.size() == 20) begin
      chk("min_interval", rise_q[7] - rise_q[6], 4);
      chk("min_high", hi_q[7], 1);
    end

    // Reset mid-move returns every output to reset value without done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 16'(10); cmd_period = 16'(40); cmd_dir = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    chk("mid_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_step", int'(step), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_steps_left", int'(steps_left), 0);
    chk("mrst_dir", int'(dir), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_done_after", int'(done), 0);

    exp_pos = 0;
    run_move(7, 60, 1'b1, -1, 0, -1, 0, n, lat, sl, to);
    exp_pos += n;
    run_move(3, 60, 1'b0, -1, 0, -1, 0, n, lat, sl, to);
    exp_pos -= n;
`ifdef STEP_RAMP_CTRL_POS_EN
    chk("position_7_3", int'(position), 4);
`endif

    for (int i = 0; i < 25; i++) begin
      steps = int'($urandom_range(0, 12));
      per   = int'($urandom_range(0, 160));
      d     = 1'($urandom_range(0, 1));
      model(steps, per, en, elat);
      run_move(steps, per, d, -1, 0, -1, 0, n, lat, sl, to);
      chk($sformatf("rnd%0d_timeout", i), int'(to), 0);
      chk($sformatf("rnd%0d_nsteps(s=%0d,p=%0d)", i, steps, per), n, en);
      chk($sformatf("rnd%0d_latency(s=%0d,p=%0d)", i, steps, per), lat, elat);
      chk($sformatf("rnd%0d_dir", i), int'(dir), int'(d));
      chk($sformatf("rnd%0d_steps_left", i), sl, 0);
      exp_pos += d ? n : -n;
    end
`ifdef STEP_RAMP_CTRL_POS_EN
    chk("position_random", int'(position), exp_pos);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
